// File: rtl/car_lane_sensor_pkg.sv
// Shared definitions for the car lane sensor front-end.
// Holds the lane state encoding, default parameter values and the
// width of the optional violation counter.
package lane_sensor_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'b00,
    OCCUPIED = 2'b01,
    FULL     = 2'b10,
    FAULT    = 2'b11
  } lane_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_CNT_W           = 3;
  localparam int unsigned DEF_OCC_W           = 4;
  localparam int unsigned VIOL_CNT_W          = 8;

endpackage

// File: rtl/car_lane_sensor_if.sv
// Signal bundle between the roadside loops/barrier readback and the lane
// sensor. The master side drives the raw loops and barrier state, the
// slave side (the sensor) returns pulses, occupancy and lane state.
// Optional macro VIOLATION_COUNT_EN adds o_violation_count.
//   i_loopEntry / i_loopExit : raw asynchronous loop detectors
//   i_carBarrier             : barrier state readback, 1 = closed
//   o_carIn / o_carOut       : one-cycle accepted entry/exit pulses
//   o_occupancy / o_hasCar   : cars on the bridge / occupancy != 0
//   o_violation              : one-cycle violation pulse
//   o_lane_state             : lane FSM state
interface car_lane_sensor_if #(
  parameter int unsigned OCC_W = lane_sensor_pkg::DEF_OCC_W
);
  logic                           i_loopEntry;
  logic                           i_loopExit;
  logic                           i_carBarrier;
  logic                           o_carIn;
  logic                           o_carOut;
  logic [OCC_W-1:0]               o_occupancy;
  logic                           o_hasCar;
  logic                           o_violation;
  lane_sensor_pkg::lane_state_t   o_lane_state;
`ifdef VIOLATION_COUNT_EN
  logic [lane_sensor_pkg::VIOL_CNT_W-1:0] o_violation_count;
`endif

  modport master (
    output i_loopEntry, output i_loopExit, output i_carBarrier,
`ifdef VIOLATION_COUNT_EN
    input  o_violation_count,
`endif
    input  o_carIn, input o_carOut, input o_occupancy, input o_hasCar,
    input  o_violation, input o_lane_state
  );

  modport slave (
    input  i_loopEntry, input i_loopExit, input i_carBarrier,
`ifdef VIOLATION_COUNT_EN
    output o_violation_count,
`endif
    output o_carIn, output o_carOut, output o_occupancy, output o_hasCar,
    output o_violation, output o_lane_state
  );
endinterface

// File: rtl/car_lane_sensor_loop_debounce.sv
// Synchroniser, debouncer and rising-edge detector for one inductive loop.
//   clk, rst : system clock, synchronous active-high reset
//   raw      : asynchronous loop input
//   level    : debounced stable level
//   rise     : one-cycle pulse when the stable level goes 0 -> 1
module loop_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);
  logic             sync_a;
  logic             sync_b;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      level  <= 1'b0;
      rise   <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      rise   <= 1'b0;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // This is the DEBOUNCE_CYCLES-th differing sample: accept the new level
        level <= ~level;
        rise  <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/car_lane_sensor.sv
// Lane sensor front-end for the drawbridge controller: debounces the entry
// and exit loops, emits carIn/carOut pulses, tracks occupancy, flags
// barrier-run / phantom-exit / overflow violations and runs the lane FSM.
// Optional macro VIOLATION_COUNT_EN adds a saturating violation counter.
//   i_clk, i_reset : system clock, synchronous active-high reset
//   lane           : car_lane_sensor_if slave (loops, barrier, results)
module car_lane_sensor
  import lane_sensor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter int unsigned OCC_W           = DEF_OCC_W
) (
  input logic               i_clk,
  input logic               i_reset,
  car_lane_sensor_if.slave  lane
);
  localparam logic [OCC_W-1:0] OCC_MAX = '1;

  logic             entry_level, entry_rise;
  logic             exit_level, exit_rise;
  logic [OCC_W-1:0] occ, occ_next;
  lane_state_t      state, state_next;
  logic             car_in, car_in_next;
  logic             car_out, car_out_next;
  logic             viol, viol_next;

  loop_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_entry (
    .clk(i_clk), .rst(i_reset), .raw(lane.i_loopEntry),
    .level(entry_level), .rise(entry_rise)
  );

  loop_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_exit (
    .clk(i_clk), .rst(i_reset), .raw(lane.i_loopExit),
    .level(exit_level), .rise(exit_rise)
  );

  always_comb begin
    occ_next     = occ;
    car_in_next  = 1'b0;
    car_out_next = 1'b0;
    viol_next    = 1'b0;
    state_next   = state;

    if (entry_rise && exit_rise) begin
      // Entry is taken first, so the pair nets out even at 0 or max
      car_in_next  = 1'b1;
      car_out_next = 1'b1;
      viol_next    = lane.i_carBarrier;
    end else if (entry_rise) begin
      if (occ == OCC_MAX) begin
        viol_next = 1'b1;
      end else begin
        car_in_next = 1'b1;
        occ_next    = occ + 1'b1;
      end
      if (lane.i_carBarrier) viol_next = 1'b1;
    end else if (exit_rise) begin
      if (occ == '0) begin
        viol_next = 1'b1;
      end else begin
        car_out_next = 1'b1;
        occ_next     = occ - 1'b1;
      end
    end

    if (viol_next) begin
      state_next = FAULT;
    end else if (state == FAULT && (entry_level || exit_level)) begin
      state_next = FAULT;
    end else if (occ_next == '0) begin
      state_next = EMPTY;
    end else if (occ_next == OCC_MAX) begin
      state_next = FULL;
    end else begin
      state_next = OCCUPIED;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= EMPTY;
      occ     <= '0;
      car_in  <= 1'b0;
      car_out <= 1'b0;
      viol    <= 1'b0;
    end else begin
      state   <= state_next;
      occ     <= occ_next;
      car_in  <= car_in_next;
      car_out <= car_out_next;
      viol    <= viol_next;
    end
  end

`ifdef VIOLATION_COUNT_EN
  logic [VIOL_CNT_W-1:0] viol_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      viol_count <= '0;
    end else if (viol_next && viol_count != '1) begin
      viol_count <= viol_count + 1'b1;
    end
  end

  assign lane.o_violation_count = viol_count;
`endif

  assign lane.o_carIn      = car_in;
  assign lane.o_carOut     = car_out;
  assign lane.o_occupancy  = occ;
  assign lane.o_hasCar     = (occ != '0);
  assign lane.o_violation  = viol;
  assign lane.o_lane_state = state;
endmodule

// File: tb/tb_car_lane_sensor.sv
// Directed self-checking bench for car_lane_sensor (DEBOUNCE_CYCLES=4, OCC_W=4).
module tb_car_lane_sensor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_in = 0, n_out = 0, n_viol = 0;
  int   base_in, base_out, base_viol;

  car_lane_sensor_if bus ();

  car_lane_sensor dut (
    .i_clk   (clk),
    .i_reset (rst),
    .lane    (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.o_carIn)     n_in++;
    if (bus.o_carOut)    n_out++;
    if (bus.o_violation) n_viol++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold the chosen loops for 8 cycles then release for 8; the accepted
  // pulse lands on the 7th cycle and the FSM has settled after release.
  task automatic car(input logic en, input logic ex);
    bus.i_loopEntry = en;
    bus.i_loopExit  = ex;
    tick(8);
    bus.i_loopEntry = 1'b0;
    bus.i_loopExit  = 1'b0;
    tick(8);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_carIn"},  32'(bus.o_carIn), 0);
    check({tag, "_carOut"}, 32'(bus.o_carOut), 0);
    check({tag, "_occ"},    32'(bus.o_occupancy), 0);
    check({tag, "_hasCar"}, 32'(bus.o_hasCar), 0);
    check({tag, "_viol"},   32'(bus.o_violation), 0);
    check({tag, "_state"},  32'(bus.o_lane_state), 0);
  endtask

  initial begin
    bus.i_loopEntry  = 1'b0;
    bus.i_loopExit   = 1'b0;
    bus.i_carBarrier = 1'b0;
    tick(2);
    check_idle("reset");
    rst = 1'b0;
    tick(2);

    // Glitch of 3 cycles is filtered
    bus.i_loopEntry = 1'b1;
    tick(3);
    bus.i_loopEntry = 1'b0;
    tick(10);
    check("glitch_pulses", 32'(n_in), 0);
    check("glitch_occ", 32'(bus.o_occupancy), 0);

    // Single entry: pulse exactly on the 7th edge after the loop rises
    bus.i_loopEntry = 1'b1;
    tick(6);
    check("entry_early", 32'(bus.o_carIn), 0);
    tick(1);
    check("entry_pulse", 32'(bus.o_carIn), 1);
    check("entry_occ", 32'(bus.o_occupancy), 1);
    check("entry_hasCar", 32'(bus.o_hasCar), 1);
    check("entry_state", 32'(bus.o_lane_state), 1);
    tick(1);
    check("entry_one_cycle", 32'(bus.o_carIn), 0);
    bus.i_loopEntry = 1'b0;
    tick(10);
    check("entry_count", 32'(n_in), 1);
    car(1'b0, 1'b1);
    check("setup_occ0", 32'(bus.o_occupancy), 0);

    // Two entries then two exits
    base_in = n_in; base_out = n_out; base_viol = n_viol;
    car(1'b1, 1'b0); check("seq_occ_a", 32'(bus.o_occupancy), 1);
    car(1'b1, 1'b0); check("seq_occ_b", 32'(bus.o_occupancy), 2);
    check("seq_state_b", 32'(bus.o_lane_state), 1);
    car(1'b0, 1'b1); check("seq_occ_c", 32'(bus.o_occupancy), 1);
    car(1'b0, 1'b1); check("seq_occ_d", 32'(bus.o_occupancy), 0);
    check("seq_in",    32'(n_in - base_in), 2);
    check("seq_out",   32'(n_out - base_out), 2);
    check("seq_viol",  32'(n_viol - base_viol), 0);
    check("seq_state", 32'(bus.o_lane_state), 0);

    // Barrier run
    bus.i_carBarrier = 1'b1;
    bus.i_loopEntry  = 1'b1;
    tick(7);
    check("barrier_carIn", 32'(bus.o_carIn), 1);
    check("barrier_viol",  32'(bus.o_violation), 1);
    check("barrier_state", 32'(bus.o_lane_state), 3);
    check("barrier_occ",   32'(bus.o_occupancy), 1);
    bus.i_carBarrier = 1'b0;
    tick(3);
    check("barrier_hold", 32'(bus.o_lane_state), 3);
    bus.i_loopEntry = 1'b0;
    tick(6);
    check("barrier_hold_late", 32'(bus.o_lane_state), 3);
    tick(1);
    check("barrier_release", 32'(bus.o_lane_state), 1);
    tick(8);
    car(1'b0, 1'b1);

    // Phantom exit at zero
    bus.i_loopExit = 1'b1;
    tick(7);
    check("phantom_carOut", 32'(bus.o_carOut), 0);
    check("phantom_viol",   32'(bus.o_violation), 1);
    check("phantom_occ",    32'(bus.o_occupancy), 0);
    check("phantom_state",  32'(bus.o_lane_state), 3);
    bus.i_loopExit = 1'b0;
    tick(8);
    check("phantom_release", 32'(bus.o_lane_state), 0);

    // Fill to max, then overflow
    for (int i = 1; i <= 15; i++) begin
      car(1'b1, 1'b0);
      check("fill_occ", 32'(bus.o_occupancy), 32'(i));
    end
    check("full_state", 32'(bus.o_lane_state), 2);
    bus.i_loopEntry = 1'b1;
    tick(7);
    check("ovf_carIn", 32'(bus.o_carIn), 0);
    check("ovf_viol",  32'(bus.o_violation), 1);
    check("ovf_occ",   32'(bus.o_occupancy), 15);
    check("ovf_state", 32'(bus.o_lane_state), 3);
    bus.i_loopEntry = 1'b0;
    tick(8);
    check("ovf_release", 32'(bus.o_lane_state), 2);

    // Reset, three entries, then simultaneous entry+exit at 3
    rst = 1'b1;
    tick(1);
    check_idle("reset_full");
    rst = 1'b0;
    tick(2);
    car(1'b1, 1'b0); car(1'b1, 1'b0); car(1'b1, 1'b0);
    check("three_occ", 32'(bus.o_occupancy), 3);
    bus.i_loopEntry = 1'b1;
    bus.i_loopExit  = 1'b1;
    tick(7);
    check("both_carIn",  32'(bus.o_carIn), 1);
    check("both_carOut", 32'(bus.o_carOut), 1);
    check("both_occ",    32'(bus.o_occupancy), 3);
    check("both_viol",   32'(bus.o_violation), 0);
    bus.i_loopEntry = 1'b0;
    bus.i_loopExit  = 1'b0;
    tick(8);

    // Reset mid-debounce
    bus.i_loopEntry = 1'b1;
    tick(3);
    rst = 1'b1;
    bus.i_loopEntry = 1'b0;
    tick(1);
    check_idle("reset_mid");
    rst = 1'b0;
    base_in = n_in;
    tick(10);
    check("no_late_pulse", 32'(n_in - base_in), 0);
    check("no_late_occ",   32'(bus.o_occupancy), 0);

    // Simultaneous entry+exit at zero: no phantom violation
    bus.i_loopEntry = 1'b1;
    bus.i_loopExit  = 1'b1;
    tick(7);
    check("zero_both_carIn",  32'(bus.o_carIn), 1);
    check("zero_both_carOut", 32'(bus.o_carOut), 1);
    check("zero_both_occ",    32'(bus.o_occupancy), 0);
    check("zero_both_viol",   32'(bus.o_violation), 0);
    check("zero_both_state",  32'(bus.o_lane_state), 0);
    bus.i_loopEntry = 1'b0;
    bus.i_loopExit  = 1'b0;
    tick(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/car_lane_sensor.md
Name: car_lane_sensor

Overview:
Roadside front-end that produces the car-traffic inputs consumed by the drawbridge controller. It conditions the raw entry and exit inductive-loop detectors by synchronising and debouncing them. It emits single-cycle carIn/carOut pulses and tracks bridge occupancy. It also reads back the controller's barrier output to flag barrier-run and phantom-exit events.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a loop level change is accepted (range 1..2^CNT_W-1)
CNT_W, 3, debounce counter width
OCC_W, 4, occupancy counter width; maximum count is 2^OCC_W-1

Ports:
i_clk  input  1  single system clock, rising edge
i_reset  input  1  synchronous, active-high reset
i_loopEntry  input  1  raw entry loop detector, asynchronous, 1 = vehicle present
i_loopExit  input  1  raw exit loop detector, asynchronous, 1 = vehicle present
i_carBarrier  input  1  barrier state from drawbridge controller, 1 = closed
o_carIn  output  1  one-cycle pulse per accepted entry
o_carOut  output  1  one-cycle pulse per accepted exit
o_occupancy  output  OCC_W  cars currently on the bridge
o_hasCar  output  1  o_occupancy != 0
o_violation  output  1  one-cycle pulse on barrier-run, phantom exit or overflow
o_lane_state  output  2  lane FSM state

Behaviour:
- Reset: synchronous on i_clk when i_reset=1. Every output is 0, lane state is EMPTY, sync flops are 0, stable loop levels are 0, and debounce counters are 0. Reset mid-operation discards pending debounce counts and occupancy.
- Per loop: 2-flop synchroniser followed by the debouncer.
  - Counter increments while the synced level differs from the stable level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the stable level toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no output.
- Latency: raw rising edge first sampled at edge k → o_carIn (or o_carOut) is high for exactly one cycle, registered at edge k+2+DEBOUNCE_CYCLES. The falling edge of the stable level produces no pulse.
- Entry accepted (stable entry rising):
  - If occupancy < max: o_carIn=1 and occupancy+1.
  - If occupancy == max: o_carIn=0, occupancy held, o_violation=1 (overflow).
  - If i_carBarrier=1 in that cycle: the car is still counted and o_violation=1 (barrier run).
- Exit accepted (stable exit rising):
  - If occupancy > 0: o_carOut=1 and occupancy-1.
  - If occupancy == 0: o_carOut=0 and o_violation=1 (phantom exit); no wrap-around.
- Simultaneous entry and exit in the same cycle:
  - Both pulses fire and occupancy is unchanged.
  - Exception at occupancy 0: entry is processed first, so the net result is still unchanged and no phantom-exit violation is raised.
- o_violation is a single pulse even when several causes coincide.
- Lane FSM (registered, evaluated after the occupancy update):
  - EMPTY=00: occupancy 0.
  - OCCUPIED=01: 0 < occupancy < max.
  - FULL=10: occupancy == max.
  - FAULT=11: entered on any violation. Held while either stable loop is 1. Exits to EMPTY/OCCUPIED/FULL per occupancy on the first cycle both stable loops are 0.
- o_hasCar is combinational from the occupancy register.

Optional Feature:
VIOLATION_COUNT_EN.
- Defined: adds output o_violation_count [7:0], which counts o_violation pulses, saturates at 255 and is cleared by reset.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package lane_sensor_pkg holds:
  - lane state encodings EMPTY, OCCUPIED, FULL, FAULT;
  - the 2-bit lane state type;
  - default widths;
  - the violation counter width (8).
- One sub-module, loop_debounce (synchroniser + debounce + rising-edge pulse), parameterised by DEBOUNCE_CYCLES and CNT_W. It is instantiated twice, once for entry and once for exit.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and OCC_W=4.
1. Entry loop high at edge 10 for 8 cycles → o_carIn pulses once at edge 16; o_occupancy=1, o_hasCar=1, o_lane_state=01.
2. Entry loop glitch high for 3 cycles → no o_carIn; occupancy stays 0.
3. Two entries then two exits with i_carBarrier=0 → occupancy 1,2,1,0; four pulses; o_violation never asserted; final o_lane_state=00.
4. Entry while i_carBarrier=1 → o_carIn=1, o_violation=1 in the same cycle; o_lane_state=11 until the entry loop is released, then 01.
5. Exit at occupancy 0 → o_carOut=0, o_violation=1, occupancy stays 0. Then 16 entries → 15th entry gives FULL (o_lane_state=10), 16th gives overflow o_violation with occupancy held at 15.
6. Entry and exit stable-rising in the same cycle at occupancy 3 → both pulses fire, occupancy stays 3. Then i_reset mid-debounce → all outputs 0 the next cycle and no late pulse.
